// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: op classes, opcodes and funct codes used by
// both the control decoder and the instruction encoder.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    CLS_RTYPE = 4'd0,
    CLS_JR    = 4'd1,
    CLS_LW    = 4'd2,
    CLS_SW    = 4'd3,
    CLS_BEQ   = 4'd4,
    CLS_BNE   = 4'd5,
    CLS_J     = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_ADDI  = 4'd8,
    CLS_ADDIU = 4'd9,
    CLS_ANDI  = 4'd10,
    CLS_ORI   = 4'd11,
    CLS_XORI  = 4'd12
  } op_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_entry_t;

  function automatic logic [31:0] enc_itype(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a combinational head output.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt the pointers.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Builds MIPS instruction words from op-class requests and streams them into
// instruction memory at auto-incrementing word addresses.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e      r_state;
  logic        r_alive;
  logic        r_done;
  logic        r_err;
  logic        r_last_moved;
  logic [31:0] r_addr;

  logic        w_legal;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  fifo_entry_t w_head;
  fifo_entry_t w_push_entry;
  logic        w_ill_last;
  logic        w_one_left;
  logic        w_pop_last;
  logic        w_finish;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (op_class_e'(in_class))
      CLS_RTYPE: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      CLS_JR:    w_word = {OP_RTYPE, in_rs, 15'd0, FUNCT_JR};
      CLS_LW:    w_word = enc_itype(OP_LW,    in_rs, in_rt, in_imm);
      CLS_SW:    w_word = enc_itype(OP_SW,    in_rs, in_rt, in_imm);
      CLS_BEQ:   w_word = enc_itype(OP_BEQ,   in_rs, in_rt, in_imm);
      CLS_BNE:   w_word = enc_itype(OP_BNE,   in_rs, in_rt, in_imm);
      CLS_ADDI:  w_word = enc_itype(OP_ADDI,  in_rs, in_rt, in_imm);
      CLS_ADDIU: w_word = enc_itype(OP_ADDIU, in_rs, in_rt, in_imm);
      CLS_ANDI:  w_word = enc_itype(OP_ANDI,  in_rs, in_rt, in_imm);
      CLS_ORI:   w_word = enc_itype(OP_ORI,   in_rs, in_rt, in_imm);
      CLS_XORI:  w_word = enc_itype(OP_XORI,  in_rs, in_rt, in_imm);
      CLS_J:     w_word = {OP_J,   in_target};
      CLS_JAL:   w_word = {OP_JAL, in_target};
      default:   w_legal = 1'b0;
    endcase
  end

  assign in_ready     = r_alive && !w_full && (r_state != S_DRAIN);
  assign w_accept     = in_valid && in_ready;
  assign w_push       = w_accept && w_legal;
  assign w_pop        = !w_empty && out_ready;
  assign w_push_entry = '{last: in_last, word: w_word};

  // An illegal request carrying last hands its last flag to the newest queued
  // word; when that word is also the only one left, it is the program's final write.
  assign w_ill_last = w_accept && !w_legal && in_last;
  assign w_one_left = (w_count == CW'(1));
  assign w_pop_last = w_head.last || ((r_last_moved || w_ill_last) && w_one_left);
  assign w_finish   = (w_pop && w_pop_last) || (w_ill_last && w_empty);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_alive      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_last_moved <= 1'b0;
      r_addr       <= BASE_ADDR;
    end else begin
      r_alive <= 1'b1;
      r_done  <= w_finish;
      if (w_accept && !w_legal) r_err <= 1'b1;

      if (w_finish)   r_addr <= BASE_ADDR;
      else if (w_pop) r_addr <= r_addr + 32'd4;

      if (w_finish) begin
        r_state      <= S_IDLE;
        r_last_moved <= 1'b0;
      end else if (w_accept && in_last) begin
        r_state      <= S_DRAIN;
        r_last_moved <= !w_legal;
      end else if (w_accept && r_state == S_IDLE) begin
        r_state <= S_RUN;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_head.word;
  assign out_addr  = r_addr;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder against a queue-based
// reference model of the program image.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr, out_data;
  logic        done, err;

  logic tb_ready = 1'b0, rand_mode = 1'b0, rand_ready = 1'b0;
  assign out_ready = rand_mode ? rand_ready : tb_ready;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_addr = 32'h0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .done(done), .err(err)
  );

  always @(posedge clk) begin
    #1;
    rand_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_addr, out_data});
      $display("WR addr=%08h data=%08h", out_addr, out_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference encoding straight from the ISA field layout; bit 32 = legal.
  function automatic logic [32:0] ref_encode(input logic [3:0] cls, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned op;
    int unsigned w;
    op = 0;
    case (cls)
      CLS_LW: op = 'h23;    CLS_SW: op = 'h2B;
      CLS_BEQ: op = 'h04;   CLS_BNE: op = 'h05;
      CLS_ADDI: op = 'h08;  CLS_ADDIU: op = 'h09;
      CLS_ANDI: op = 'h0C;  CLS_ORI: op = 'h0D;  CLS_XORI: op = 'h0E;
      default: op = 0;
    endcase
    if (cls == CLS_RTYPE)
      w = 32'(rs) * (1 << 21) + 32'(rt) * (1 << 16) + 32'(rd) * (1 << 11) + 32'(sh) * 64 + 32'(fn);
    else if (cls == CLS_JR)
      w = 32'(rs) * (1 << 21) + 8;
    else if (cls == CLS_J)
      w = 2 * (1 << 26) + 32'(tgt);
    else if (cls == CLS_JAL)
      w = 3 * (1 << 26) + 32'(tgt);
    else if (op != 0)
      w = op * (1 << 26) + 32'(rs) * (1 << 21) + 32'(rt) * (1 << 16) + 32'(imm);
    else
      return {1'b0, 32'h0};
    return {1'b1, w};
  endfunction

  task automatic send(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
      input logic [25:0] tgt, input logic last);
    logic [32:0] r;
    bit ok;
    @(posedge clk); #1;
    in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
      r = ref_encode(cls, rs, rt, rd, sh, fn, imm, tgt);
      if (r[32]) begin
        exp_q.push_back({m_addr, r[31:0]});
        m_addr += 32'd4;
      end
      if (last) m_addr = 32'h0;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1 class=%0d", cls);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_i(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm, input logic last);
    send(cls, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0, last);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 600 && obs_q.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tb_ready = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", out_addr); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_addi();
    int d0;
    clear_queues(); tb_ready = 1'b1; d0 = done_cnt;
    send_i(CLS_ADDI, 5'd0, 5'd8, 16'h0005, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL addi_addr got %h want 0", out_addr); end
    checks++; if (out_data !== 32'h2008_0005) begin errors++; $display("FAIL addi_data got %h want 20080005", out_data); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL addi_done got %b want 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_pulse got %b want 0", done); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL addi_done_cnt got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_stream();
    int d0;
    clear_queues(); tb_ready = 1'b1; d0 = done_cnt;
    send(CLS_RTYPE, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    send_i(CLS_LW, 5'd29, 5'd8, 16'h0004, 1'b0);
    send_i(CLS_SW, 5'd29, 5'd9, 16'h0008, 1'b0);
    send_i(CLS_BEQ, 5'd8, 5'd9, 16'hFFFE, 1'b0);
    send(CLS_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b0);
    send(CLS_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h40, 1'b1);
    wait_writes(6);
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL stream_len got %0d want 6", obs_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stream_wr%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
      end
    end
    checks++; if (obs_q[0] !== 64'h0000_0000_012A_4020) begin errors++; $display("FAIL stream_add got %h want 00000000012a4020", obs_q[0]); end
    checks++; if (obs_q[1] !== 64'h0000_0004_8FA8_0004) begin errors++; $display("FAIL stream_lw got %h want 000000048fa80004", obs_q[1]); end
    checks++; if (obs_q[4] !== 64'h0000_0010_0800_0010) begin errors++; $display("FAIL stream_j got %h want 0000001008000010", obs_q[4]); end
    checks++; if (obs_q[5] !== 64'h0000_0014_0C00_0040) begin errors++; $display("FAIL stream_jal got %h want 000000140c000040", obs_q[5]); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stream_done_cnt got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int d0;
    logic [31:0] a0, dat0;
    clear_queues(); tb_ready = 1'b0; d0 = done_cnt;
    for (int i = 0; i < DEPTH; i++)
      send_i(CLS_ORI, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    a0 = exp_q[0][63:32]; dat0 = exp_q[0][31:0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_addr !== a0 || out_data !== dat0) begin
        errors++; $display("FAIL bp_stable got v=%b a=%h d=%h want v=1 a=%h d=%h", out_valid, out_addr, out_data, a0, dat0);
      end
    end
    @(posedge clk); #1; tb_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk); #1;
      checks++; if (obs_q.size() != k) begin errors++; $display("FAIL bp_rate got %0d want %0d", obs_q.size(), k); end
    end
    send_i(CLS_XORI, 5'd1, 5'd2, 16'h1234, 1'b1);
    wait_writes(DEPTH + 1);
    checks++; if (obs_q.size() != DEPTH + 1) begin errors++; $display("FAIL bp_len got %0d want %0d", obs_q.size(), DEPTH + 1); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_wr%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_illegal();
    int d0;
    clear_queues(); tb_ready = 1'b1; d0 = done_cnt;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_pre got %b want 0", err); end
    send_i(CLS_ADDI, 5'd1, 5'd2, 16'h0007, 1'b0);
    send(4'hF, 5'd3, 5'd3, 5'd3, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
    send_i(CLS_ORI, 5'd3, 5'd4, 16'hBEEF, 1'b0);
    send_i(CLS_XORI, 5'd5, 5'd6, 16'h0001, 1'b1);
    wait_writes(3);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL ill_len got %0d want 3", obs_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ill_wr%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", err); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ill_done_cnt got %0d want 1", done_cnt - d0); end

    // Illegal request carrying last while a word is still queued.
    clear_queues(); tb_ready = 1'b0; d0 = done_cnt;
    send_i(CLS_ANDI, 5'd7, 5'd8, 16'h00FF, 1'b0);
    send(4'hE, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ill_last_drain got %b want 0", in_ready); end
    @(posedge clk); #1; tb_ready = 1'b1;
    wait_writes(1);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL ill_last_wr got n=%0d %h want n=1 %h", obs_q.size(), obs_q[0], exp_q[0]);
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ill_last_done got %0d want 1", done_cnt - d0); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL ill_last_addr got %h want 0", out_addr); end

    // Illegal request carrying last with nothing queued.
    clear_queues(); d0 = done_cnt;
    send(4'hD, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ill_empty_done got %b want 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ill_empty_pulse got %b want 0", done); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ill_empty_wr got %0d want 0", obs_q.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky got %b want 1", err); end
  endtask

  task automatic test_jr_equiv();
    clear_queues(); tb_ready = 1'b1;
    send(CLS_JR, 5'd31, 5'd7, 5'd9, 5'd3, 6'h2A, 16'h0, 26'h0, 1'b0);
    send(CLS_RTYPE, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0, 26'h0, 1'b1);
    wait_writes(2);
    checks++; if (obs_q[0][31:0] !== 32'h03E0_0008) begin errors++; $display("FAIL jr_word got %h want 03e00008", obs_q[0][31:0]); end
    checks++; if (obs_q[1][31:0] !== 32'h03E0_0008) begin errors++; $display("FAIL rtype_jr_word got %h want 03e00008", obs_q[1][31:0]); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL jr_wr%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int d0, len;
    clear_queues(); rand_mode = 1'b1; d0 = done_cnt;
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(3, 12);
      for (int i = 0; i < len; i++)
        send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom), (i == len - 1));
    end
    wait_writes(exp_q.size());
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_wr%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
      end
    end
    checks++; if (done_cnt - d0 != 5) begin errors++; $display("FAIL rand_done_cnt got %0d want 5", done_cnt - d0); end
    rand_mode = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    int d0;
    clear_queues(); tb_ready = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rd_err_pre got %b want 1", err); end
    send_i(CLS_ADDI, 5'd1, 5'd1, 16'h0011, 1'b0);
    send_i(CLS_ORI, 5'd2, 5'd2, 16'h0022, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rd_pre got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_async got %b want 0", out_valid); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL rd_addr got %h want 0", out_addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err); end
    clear_queues(); m_addr = 32'h0; d0 = done_cnt;
    @(posedge clk); #1; rst_n = 1'b1; tb_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_post_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd_post_ready got %b want 1", in_ready); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rd_no_done got %0d want 0", done_cnt - d0); end
    send_i(CLS_ADDI, 5'd0, 5'd8, 16'h0005, 1'b1);
    wait_writes(1);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rd_restart got n=%0d %h want n=1 %h", obs_q.size(), obs_q[0], exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_addi();
    test_stream();
    test_backpressure();
    test_illegal();
    test_jr_equiv();
    test_random();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
